// File: rtl/instr_encoder_loader.sv
// Builds 32-bit MIPS instruction words from a mnemonic index plus fields and streams them out with an auto-incrementing word address.
// Latency: 1 cycle from input accept to out_valid; single output register stage, 1 word/cycle sustained.
// Backpressure: in_ready drops while the output slot is occupied and not draining, or once the fill capacity is reached.
module instr_encoder_loader #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              illegal
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {K_R, K_I, K_J, K_BAD} kind_t;

  kind_t       kind;
  logic [5:0]  r_func;
  logic [5:0]  i_op;
  logic [4:0]  rs_eff;
  logic [31:0] enc_instr;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W:0]   count_q,     count_d;
  logic              illegal_q,   illegal_d;

  logic accept;
  logic drain;

  // Mnemonic lookup: classify format and pick func/opcode, then assemble the word.
  always_comb begin
    kind   = K_BAD;
    r_func = 6'b000000;
    i_op   = 6'b000000;
    case (in_mnem)
      5'd0:  begin kind = K_R; r_func = 6'b100000; end
      5'd1:  begin kind = K_R; r_func = 6'b100001; end
      5'd2:  begin kind = K_R; r_func = 6'b100010; end
      5'd3:  begin kind = K_R; r_func = 6'b100011; end
      5'd4:  begin kind = K_R; r_func = 6'b100100; end
      5'd5:  begin kind = K_R; r_func = 6'b100101; end
      5'd6:  begin kind = K_R; r_func = 6'b100110; end
      5'd7:  begin kind = K_R; r_func = 6'b101000; end
      5'd8:  begin kind = K_R; r_func = 6'b101010; end
      5'd9:  begin kind = K_R; r_func = 6'b101011; end
      5'd10: begin kind = K_I; i_op   = 6'b001000; end
      5'd11: begin kind = K_I; i_op   = 6'b001001; end
      5'd12: begin kind = K_I; i_op   = 6'b001100; end
      5'd13: begin kind = K_I; i_op   = 6'b001101; end
      5'd14: begin kind = K_I; i_op   = 6'b001110; end
      5'd15: begin kind = K_I; i_op   = 6'b001010; end
      5'd16: begin kind = K_I; i_op   = 6'b001011; end
      5'd17: begin kind = K_I; i_op   = 6'b100011; end
      5'd18: begin kind = K_I; i_op   = 6'b101011; end
      5'd19: begin kind = K_I; i_op   = 6'b001111; end
      5'd20: begin kind = K_I; i_op   = 6'b000101; end
      5'd21: begin kind = K_I; i_op   = 6'b000100; end
      5'd22: begin kind = K_J; end
      default: kind = K_BAD;
    endcase
    // LUI has no source register; the rs slot is architecturally zero.
    rs_eff = (in_mnem == 5'd19) ? 5'd0 : in_rs;
    case (kind)
      K_R:     enc_instr = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, r_func};
      K_I:     enc_instr = {i_op, rs_eff, in_rt, in_imm};
      K_J:     enc_instr = {6'b000010, in_target};
      default: enc_instr = 32'h0000_0000;
    endcase
  end

  assign full     = (count_q == CAP);
  assign in_ready = !full && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid_q && out_ready;

  // Next-state for the output slot, address counter, fill count and sticky error; clear overrides any handshake.
  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    count_d     = count_q;
    illegal_d   = illegal_q;
    if (clear) begin
      out_valid_d = 1'b0;
      out_instr_d = 32'h0000_0000;
      out_addr_d  = BASE;
      addr_d      = BASE;
      count_d     = '0;
      illegal_d   = 1'b0;
    end else begin
      if (drain) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        if (kind == K_BAD) begin
          // Consumed but produces no word; counter and count are untouched.
          illegal_d = 1'b1;
        end else begin
          out_valid_d = 1'b1;
          out_instr_d = enc_instr;
          out_addr_d  = addr_q;
          addr_d      = addr_q + 1'b1;
          count_d     = count_q + 1'b1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0000_0000;
      out_addr_q  <= BASE;
      addr_q      <= BASE;
      count_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign out_addr   = out_addr_q;
  assign word_count = count_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed scenarios plus randomized traffic against a table-driven reference model.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_mnem = '0, in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_addr;
  logic [31:0] out_instr;
  logic [10:0] word_count;
  logic        full;
  logic        illegal;

  // small-capacity instance shares the field inputs
  logic        clear_s = 1'b0, in_valid_s = 1'b0, out_ready_s = 1'b0;
  logic        in_ready_s, out_valid_s, full_s, illegal_s;
  logic [1:0]  out_addr_s;
  logic [31:0] out_instr_s;
  logic [2:0]  word_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr), .word_count(word_count),
    .full(full), .illegal(illegal)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_s (
    .clk(clk), .rst(rst), .clear(clear_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_addr(out_addr_s), .out_instr(out_instr_s), .word_count(word_count_s),
    .full(full_s), .illegal(illegal_s)
  );

  // ---------------- reference model (main instance, 1024-word capacity) ----------------
  logic        m_ov;
  logic [31:0] m_instr;
  int          m_oaddr, m_addr, m_cnt;
  logic        m_ill;

  function automatic logic [31:0] ref_encode(input int m, input logic [4:0] rs, rt, rd,
                                             input logic [15:0] imm, input logic [25:0] tg);
    logic [5:0] ft [0:9];
    logic [5:0] ot [0:12];
    ft = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h28, 6'h2A, 6'h2B};
    ot = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h0F, 6'h05, 6'h04, 6'h02};
    if (m < 10) return {6'h00, rs, rt, rd, 5'd0, ft[m]};
    if (m == 22) return {ot[12], tg};
    if (m == 19) return {ot[9], 5'd0, rt, imm};
    return {ot[m-10], rs, rt, imm};
  endfunction

  function automatic logic m_ready();
    return (m_cnt != 1024) && (!m_ov || out_ready);
  endfunction

  // advance the model by one clock edge using the currently driven inputs
  task automatic model_edge();
    logic acc, drn;
    if (rst || clear) begin
      m_ov = 0; m_instr = 0; m_oaddr = 0; m_addr = 0; m_cnt = 0; m_ill = 0;
    end else begin
      acc = in_valid && m_ready();
      drn = m_ov && out_ready;
      if (drn) m_ov = 0;
      if (acc && in_mnem < 23) begin
        m_ov = 1;
        m_instr = ref_encode(int'(in_mnem), in_rs, in_rt, in_rd, in_imm, in_target);
        m_oaddr = m_addr;
        m_addr = (m_addr + 1) % 1024;
        m_cnt++;
      end else if (acc) begin
        m_ill = 1;
      end
    end
  endtask

  // drive one cycle on the main instance; returns in_ready as seen and as predicted before the edge
  task automatic drive(input logic v, input logic [4:0] mn, rs, rt, rd, input logic [15:0] imm,
                       input logic [25:0] tg, input logic ordy, output logic rdy_seen, output logic rdy_exp);
    in_valid = v; in_mnem = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_target = tg; out_ready = ordy;
    #1;
    rdy_seen = in_ready;
    rdy_exp  = m_ready();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic a, b;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, ordy, a, b);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    idle(1'b0);
    clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h exp 00000000", out_instr); end
    n_tests++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL reset_out_addr got %0d exp 0", out_addr); end
    n_tests++; if (word_count !== 11'd0) begin n_fail++; $display("FAIL reset_word_count got %0d exp 0", word_count); end
    n_tests++; if (illegal !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got ill=%b full=%b exp 0 0", illegal, full); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add();
    logic rs_seen, rs_exp;
    drive(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FFFFFF, 1'b1, rs_seen, rs_exp);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b exp 1", out_valid); end
    n_tests++; if (out_instr !== 32'h00221820) begin n_fail++; $display("FAIL add_instr got %h exp 00221820", out_instr); end
    n_tests++; if (out_addr !== 10'd0 || word_count !== 11'd1) begin n_fail++; $display("FAIL add_addr_count got %0d/%0d exp 0/1", out_addr, word_count); end
    idle(1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  mn [5]  = '{5'd10, 5'd17, 5'd19, 5'd21, 5'd22};
    logic [4:0]  rs [5]  = '{5'd1, 5'd29, 5'd9, 5'd1, 5'd0};
    logic [4:0]  rt [5]  = '{5'd2, 5'd8, 5'd7, 5'd2, 5'd0};
    logic [15:0] im [5]  = '{16'h0005, 16'h0004, 16'h1234, 16'hFFFF, 16'h0000};
    logic [31:0] exp [5] = '{32'h20220005, 32'h8FA80004, 32'h3C071234, 32'h1022FFFF, 32'h08000100};
    logic rs_seen, rs_exp;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, mn[i], rs[i], rt[i], 5'd31, im[i], 26'h0000100, 1'b1, rs_seen, rs_exp);
      n_tests++; if (rs_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b exp 1", i, rs_seen); end
      n_tests++; if (out_valid !== 1'b1 || out_instr !== exp[i] || out_addr !== 10'(i))
        begin n_fail++; $display("FAIL b2b_word[%0d] got v=%b %h @%0d exp v=1 %h @%0d", i, out_valid, out_instr, out_addr, exp[i], i); end
    end
    n_tests++; if (word_count !== 11'd5) begin n_fail++; $display("FAIL b2b_count got %0d exp 5", word_count); end
    idle(1'b1);
  endtask

  task automatic test_stall();
    logic rs_seen, rs_exp;
    do_clear();
    drive(1'b1, 5'd7, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, rs_seen, rs_exp);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, rs_seen, rs_exp);
      n_tests++; if (rs_seen !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, rs_seen); end
      n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h00853028 || out_addr !== 10'd0)
        begin n_fail++; $display("FAIL stall_hold[%0d] got v=%b %h @%0d exp v=1 00853028 @0", i, out_valid, out_instr, out_addr); end
    end
    // drain and accept the stalled request in the same cycle
    drive(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, rs_seen, rs_exp);
    n_tests++; if (rs_seen !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b exp 1", rs_seen); end
    n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h00221820 || out_addr !== 10'd1)
      begin n_fail++; $display("FAIL stall_next_word got v=%b %h @%0d exp v=1 00221820 @1", out_valid, out_instr, out_addr); end
    idle(1'b1);
    n_tests++; if (out_valid !== 1'b0 || word_count !== 11'd2) begin n_fail++; $display("FAIL stall_end got v=%b cnt=%0d exp 0/2", out_valid, word_count); end
  endtask

  task automatic test_illegal();
    logic rs_seen, rs_exp;
    do_clear();
    drive(1'b1, 5'd23, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, rs_seen, rs_exp);
    n_tests++; if (out_valid !== 1'b0 || illegal !== 1'b1 || word_count !== 11'd0)
      begin n_fail++; $display("FAIL illegal_consume got v=%b ill=%b cnt=%0d exp 0/1/0", out_valid, illegal, word_count); end
    drive(1'b1, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, rs_seen, rs_exp);
    n_tests++; if (out_valid !== 1'b1 || out_instr !== 32'h00221820 || out_addr !== 10'd0)
      begin n_fail++; $display("FAIL illegal_then_add got v=%b %h @%0d exp v=1 00221820 @0", out_valid, out_instr, out_addr); end
    n_tests++; if (word_count !== 11'd1 || illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got cnt=%0d ill=%b exp 1/1", word_count, illegal); end
    idle(1'b1);
  endtask

  task automatic test_full();
    in_mnem = 5'd13; in_rs = 5'd3; in_rt = 5'd4; in_imm = 16'h00F0;
    clear_s = 1'b1; @(posedge clk); #1; clear_s = 1'b0;
    out_ready_s = 1'b1; in_valid_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++; if (out_valid_s !== 1'b1 || out_addr_s !== 2'(i) || out_instr_s !== 32'h346400F0)
        begin n_fail++; $display("FAIL full_word[%0d] got v=%b %h @%0d exp v=1 346400f0 @%0d", i, out_valid_s, out_instr_s, out_addr_s, i); end
    end
    n_tests++; if (full_s !== 1'b1 || in_ready_s !== 1'b0 || word_count_s !== 3'd4)
      begin n_fail++; $display("FAIL full_flag got full=%b rdy=%b cnt=%0d exp 1/0/4", full_s, in_ready_s, word_count_s); end
    @(posedge clk); #1;
    n_tests++; if (out_valid_s !== 1'b0 || word_count_s !== 3'd4) begin n_fail++; $display("FAIL full_refuse got v=%b cnt=%0d exp 0/4", out_valid_s, word_count_s); end
    in_valid_s = 1'b0; clear_s = 1'b1;
    @(posedge clk); #1; clear_s = 1'b0;
    n_tests++; if (out_addr_s !== 2'd0 || word_count_s !== 3'd0 || full_s !== 1'b0 || in_ready_s !== 1'b1)
      begin n_fail++; $display("FAIL full_clear got @%0d cnt=%0d full=%b rdy=%b exp 0/0/0/1", out_addr_s, word_count_s, full_s, in_ready_s); end
    in_valid_s = 1'b1;
    @(posedge clk); #1; in_valid_s = 1'b0;
    n_tests++; if (out_valid_s !== 1'b1 || out_addr_s !== 2'd0) begin n_fail++; $display("FAIL full_restart got v=%b @%0d exp 1/0", out_valid_s, out_addr_s); end
    out_ready_s = 1'b0;
  endtask

  task automatic test_reset_midstall();
    logic rs_seen, rs_exp;
    do_clear();
    drive(1'b1, 5'd31, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, rs_seen, rs_exp);
    drive(1'b1, 5'd4, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, rs_seen, rs_exp);
    n_tests++; if (out_valid !== 1'b1 || illegal !== 1'b1) begin n_fail++; $display("FAIL midstall_setup got v=%b ill=%b exp 1/1", out_valid, illegal); end
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || word_count !== 11'd0 || illegal !== 1'b0 || out_addr !== 10'd0)
      begin n_fail++; $display("FAIL midstall_reset got v=%b cnt=%0d ill=%b @%0d exp 0/0/0/0", out_valid, word_count, illegal, out_addr); end
  endtask

  task automatic test_random();
    logic rs_seen, rs_exp;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 25)), 5'($urandom), 5'($urandom), 5'($urandom),
            16'($urandom), 26'($urandom), $urandom_range(0, 2) != 0, rs_seen, rs_exp);
      clear = 1'b0;
      n_tests++; if (rs_seen !== rs_exp) begin n_fail++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", i, rs_seen, rs_exp); end
      n_tests++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, m_ov); end
      if (m_ov) begin
        n_tests++; if (out_instr !== m_instr || out_addr !== 10'(m_oaddr))
          begin n_fail++; $display("FAIL rnd_word[%0d] got %h @%0d exp %h @%0d", i, out_instr, out_addr, m_instr, m_oaddr); end
      end
      n_tests++; if (word_count !== 11'(m_cnt) || illegal !== m_ill)
        begin n_fail++; $display("FAIL rnd_state[%0d] got cnt=%0d ill=%b exp %0d/%b", i, word_count, illegal, m_cnt, m_ill); end
    end
    idle(1'b1);
  endtask

  initial begin
    m_ov = 0; m_instr = 0; m_oaddr = 0; m_addr = 0; m_cnt = 0; m_ill = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_full();
    test_reset_midstall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart to the controller decoder. It takes a mnemonic index plus register and immediate fields, assembles the 32-bit MIPS instruction word, and streams it with an auto-incrementing address toward instruction memory.
- Used by the program loader and by self-checking benches to build instruction streams that the controller then decodes.
- Valid/ready on input and output, one output register stage.

Parameters:
ADDR_W, 10, word-address width of the output address and of the fill capacity (2^ADDR_W words).
BASE_ADDR, 0, word address loaded into the address counter on reset and on clear.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous active-high reset.
clear  input  1  synchronous restart: address back to BASE_ADDR, count and illegal cleared, output slot emptied; priority over all handshakes.
in_valid  input  1  request valid.
in_ready  output  1  block can accept a request this cycle.
in_mnem  input  5  mnemonic index, 0..22 (table below).
in_rs  input  5  rs field.
in_rt  input  5  rt field.
in_rd  input  5  rd field (R-type only).
in_imm  input  16  immediate (I-type only).
in_target  input  26  jump target (J only).
out_valid  output  1  out_instr/out_addr valid.
out_ready  input  1  consumer accepts the word.
out_addr  output  ADDR_W  word address of out_instr.
out_instr  output  32  encoded instruction.
word_count  output  ADDR_W+1  words accepted since reset/clear.
full  output  1  word_count == 2^ADDR_W.
illegal  output  1  sticky: an out-of-range mnemonic was accepted.

Behaviour:
- Mnemonic table, R-type (OP 000000, func):
  - 0 ADD 100000; 1 ADDU 100001; 2 SUB 100010; 3 SUBU 100011; 4 AND 100100
  - 5 OR 100101; 6 XOR 100110; 7 XNOR 101000; 8 SLT 101010; 9 SLTU 101011
- Mnemonic table, I-type (OP):
  - 10 ADDI 001000; 11 ADDIU 001001; 12 ANDI 001100; 13 ORI 001101; 14 XORI 001110
  - 15 SLTI 001010; 16 SLTIU 001011; 17 LW 100011; 18 SW 101011; 19 LUI 001111
  - 20 BNE 000101; 21 BEQ 000100
- Mnemonic table, J-type: 22 J 000010.
- Encoding rules:
  - R-type = {000000, rs, rt, rd, 00000, func}; shamt is always 0.
  - I-type = {OP, rs, rt, imm}; LUI forces rs = 0.
  - J = {000010, target}.
  - Fields not used by the format are ignored.
- Reset or clear:
  - out_valid = 0, out_instr = 0, out_addr = BASE_ADDR.
  - Address counter = BASE_ADDR, word_count = 0, illegal = 0.
  - A word pending in the output slot is discarded.
- Handshake rules:
  - in_ready = !full && (!out_valid || out_ready). Combinational; a fresh accept is allowed in the same cycle the output drains.
  - Accept happens when in_valid && in_ready, and loads the output register on that edge. out_valid rises the next cycle, so latency is 1 cycle.
  - Output transfer happens when out_valid && out_ready. If there is no accept in the same cycle, out_valid drops next cycle.
  - While out_valid && !out_ready, out_instr and out_addr hold stable.
- Addressing:
  - Each legal accept places the current address on out_addr, then increments the counter modulo 2^ADDR_W. The counter wraps silently.
  - Each legal accept increments word_count.
- full asserts when word_count reaches 2^ADDR_W. The block then refuses input until clear.
- Illegal mnemonic (in_mnem >= 23):
  - The request is accepted and consumed; no word is emitted.
  - Address and count are unchanged; illegal is set.
  - illegal stays set until rst/clear.
- Simultaneous clear and handshake: clear wins and the request is dropped. in_ready stays combinational during clear.

Test Plan:
- ADD rs=1 rt=2 rd=3 after reset, out_ready=1 -> one cycle later out_valid=1, out_instr=0x00221820, out_addr=0, word_count=1.
- Back-to-back accepts, out_ready=1:
  - ADDI rs=1 rt=2 imm=0x0005 -> 0x20220005 @addr 0.
  - LW rs=29 rt=8 imm=0x0004 -> 0x8FA80004 @1.
  - LUI rs=9 rt=7 imm=0x1234 -> 0x3C071234 @2.
  - BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF @3.
  - J target=0x0000100 -> 0x08000100 @4.
  - Throughput is 1 word per cycle.
- XNOR rs=4 rt=5 rd=6 with out_ready=0 for 3 cycles -> 0x00853028 held stable; in_ready=0; second request stalled; drains when out_ready=1.
- in_mnem=23 then ADD rs=1 rt=2 rd=3 -> illegal=1, no word for mnem 23; the ADD appears at addr 0 with word_count=1.
- ADDR_W=2: four legal accepts -> addresses 0,1,2,3; full=1, in_ready=0. clear -> address 0, word_count=0, full=0.
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, word_count=0, illegal=0, out_addr=BASE_ADDR.
